// File: rtl/accel_sample_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | accel_sample_ctrl_if : serial-master handshake and sample result bundle       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface accel_sample_ctrl_if;
    logic       oSPI_REQ;
    logic       oSPI_RW;
    logic [5:0] oSPI_ADDR;
    logic [7:0] oSPI_WDATA;
    logic       iSPI_ACK;
    logic [7:0] iSPI_RDATA;
    logic [9:0] oDIG;
    logic       oDIG_VALID;
    logic       oCFG_DONE;
    logic       oERR;
    logic       oOVR;

    modport master (
        output oSPI_REQ, oSPI_RW, oSPI_ADDR, oSPI_WDATA,
        output oDIG, oDIG_VALID, oCFG_DONE, oERR, oOVR,
        input  iSPI_ACK, iSPI_RDATA
    );

    modport slave (
        input  oSPI_REQ, oSPI_RW, oSPI_ADDR, oSPI_WDATA,
        input  oDIG, oDIG_VALID, oCFG_DONE, oERR, oOVR,
        output iSPI_ACK, iSPI_RDATA
    );
endinterface
`default_nettype wire

// File: rtl/accel_sample_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | accel_sample_ctrl : configures an accelerometer, then samples the X axis     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module accel_sample_ctrl #(
    parameter int unsigned SAMPLE_DIV = 2500000,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic                iCLK,
    input  logic                iRST,
    accel_sample_ctrl_if.master bus
);
    localparam int unsigned      DIV_W    = $clog2(SAMPLE_DIV);
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [5:0]       ADDR_X0  = 6'h32;
    localparam logic [5:0]       ADDR_X1  = 6'h33;

    typedef enum logic [2:0] {
        CFG_REQ, CFG_WAIT, IDLE, RD0_REQ, RD0_WAIT, RD1_REQ, RD1_WAIT, UPDATE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             req_q, req_d;
    logic             rw_q, rw_d;
    logic [5:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       lo_q, lo_d;
    logic [9:0]       dig_q, dig_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic             pend_q, pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    logic             w_tick;
    logic             w_waiting;
    logic             w_tmo_hit;
    logic             w_take;
    logic [13:0]      w_cfg_entry;

    function automatic logic [13:0] cfg_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_entry = {6'h31, 8'h40};
            2'd1:    cfg_entry = {6'h2C, 8'h09};
            default: cfg_entry = {6'h2D, 8'h08};
        endcase
    endfunction

    assign w_cfg_entry = cfg_entry(idx_q);
    assign w_tick      = done_q && (cnt_q == DIV_LAST);
    assign w_waiting   = (state_q == CFG_WAIT) || (state_q == RD0_WAIT) || (state_q == RD1_WAIT);
    // An ACK on the last allowed cycle wins over the timeout.
    assign w_tmo_hit   = w_waiting && !bus.iSPI_ACK && (tmo_q == TMO_LAST);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= CFG_REQ;
            idx_q   <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            dig_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            dig_q   <= dig_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        req_d   = req_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        dig_d   = dig_q;
        valid_d = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
        tmo_d   = '0;
        cnt_d   = '0;
        w_take  = 1'b0;

        if (done_q) begin
            cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        end
        if (w_waiting && !bus.iSPI_ACK) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            CFG_REQ: begin
                req_d   = 1'b1;
                rw_d    = 1'b0;
                addr_d  = w_cfg_entry[13:8];
                wdata_d = w_cfg_entry[7:0];
                state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (bus.iSPI_ACK) begin
                    req_d = 1'b0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 2'd2) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = CFG_REQ;
                    end
                end
            end
            IDLE: begin
                if (pend_q) begin
                    w_take  = 1'b1;
                    state_d = RD0_REQ;
                end
            end
            RD0_REQ: begin
                req_d   = 1'b1;
                rw_d    = 1'b1;
                addr_d  = ADDR_X0;
                wdata_d = '0;
                state_d = RD0_WAIT;
            end
            RD0_WAIT: begin
                if (bus.iSPI_ACK) begin
                    req_d   = 1'b0;
                    lo_d    = bus.iSPI_RDATA;
                    state_d = RD1_REQ;
                end
            end
            RD1_REQ: begin
                req_d   = 1'b1;
                rw_d    = 1'b1;
                addr_d  = ADDR_X1;
                wdata_d = '0;
                state_d = RD1_WAIT;
            end
            RD1_WAIT: begin
                // Result is loaded together with valid so the pulse lands one
                // cycle after the ACK and oDIG never shows a half update.
                if (bus.iSPI_ACK) begin
                    req_d   = 1'b0;
                    dig_d   = {bus.iSPI_RDATA[1:0], lo_q};
                    valid_d = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CFG_REQ;
            end
        endcase

        if (w_take) begin
            pend_d = w_tick;
        end else if (w_tick) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end
            pend_d = 1'b1;
        end

        if (w_tmo_hit) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            done_d  = 1'b0;
            pend_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = CFG_REQ;
        end
    end

    assign bus.oSPI_REQ   = req_q;
    assign bus.oSPI_RW    = rw_q;
    assign bus.oSPI_ADDR  = addr_q;
    assign bus.oSPI_WDATA = wdata_q;
    assign bus.oDIG       = dig_q;
    assign bus.oDIG_VALID = valid_q;
    assign bus.oCFG_DONE  = done_q;
    assign bus.oERR       = err_q;
    assign bus.oOVR       = ovr_q;

endmodule
`default_nettype wire

// File: doc/accel_sample_ctrl.md
ACCEL_SAMPLE_CTRL -- requirements
Module: accel_sample_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 2500000, meaning iCLK cycles between sample ticks (20 Hz at 50 MHz); legal range >= 64.
REQ-002 SHALL have parameter TIMEOUT, default 4095, meaning max iCLK cycles waiting for iSPI_ACK per transaction.
REQ-003 SHALL have port iCLK, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port iRST, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port oSPI_REQ, output, 1, register-access request to the serial master.
REQ-006 SHALL have port oSPI_RW, output, 1, 1 = read, 0 = write.
REQ-007 SHALL have port oSPI_ADDR, output, 6, accelerometer register address.
REQ-008 SHALL have port oSPI_WDATA, output, 8, write data.
REQ-009 SHALL have port iSPI_ACK, input, 1, one-cycle completion pulse from the master.
REQ-010 SHALL have port iSPI_RDATA, input, 8, read data, valid in the iSPI_ACK cycle.
REQ-011 SHALL have port oDIG, output, 10, latest X-axis sample, two's complement.
REQ-012 SHALL have port oDIG_VALID, output, 1, one-cycle pulse when oDIG updates.
REQ-013 SHALL have port oCFG_DONE, output, 1, high once the configuration sequence has completed.
REQ-014 SHALL have port oERR, output, 1, sticky: a transaction timed out.
REQ-015 SHALL have port oOVR, output, 1, sticky: a sample tick was dropped.

Function
REQ-016 States SHALL be CFG_REQ, CFG_WAIT, IDLE, RD0_REQ, RD0_WAIT, RD1_REQ, RD1_WAIT, UPDATE.
REQ-017 Config table SHALL be three writes in order: (0x31,0x40), (0x2C,0x09), (0x2D,0x08), indexed by a 2-bit counter.
REQ-018 Handshake: controller SHALL hold oSPI_REQ, oSPI_RW, oSPI_ADDR and oSPI_WDATA stable from assertion until the iSPI_ACK cycle; oSPI_REQ SHALL be low in the cycle after the ACK.
REQ-019 iSPI_ACK SHALL be ignored in any *_REQ or IDLE state, i.e. when no request is outstanding.
REQ-020 CFG_REQ SHALL assert a write for the current table entry -> CFG_WAIT; on ACK, increment the index; after the third ACK, set oCFG_DONE and go to IDLE, otherwise go to CFG_REQ.
REQ-021 A tick counter SHALL count 0..SAMPLE_DIV-1 and wrap, producing a one-cycle tick at wrap; it SHALL run only while oCFG_DONE=1.
REQ-022 A tick SHALL set a pending flag; a tick arriving while pending=1 SHALL set oOVR and SHALL otherwise be dropped.
REQ-023 In IDLE with pending=1, the controller SHALL clear pending and go to RD0_REQ; a tick in that same cycle SHALL set pending again without setting oOVR.
REQ-024 RD0 SHALL read address 0x32 and capture iSPI_RDATA into lo[7:0]; RD1 SHALL read address 0x33 and capture hi[1:0].
REQ-025 UPDATE SHALL load oDIG={hi[1:0],lo[7:0]}, pulse oDIG_VALID, and go to IDLE; transaction-to-valid latency SHALL be 1 cycle after the RD1 ACK.
REQ-026 oDIG SHALL hold its value between updates and SHALL never reflect a partial (lo-only) update.
REQ-027 Each *_WAIT state SHALL run a timeout counter; reaching TIMEOUT with no ACK SHALL set oERR, drop oSPI_REQ, clear oCFG_DONE, clear pending, reset the table index, and go to CFG_REQ (full reconfiguration).
REQ-028 An ACK in the same cycle the timeout is reached SHALL take priority; the transaction completes normally.
REQ-029 oERR and oOVR SHALL be cleared only by reset.

Reset
REQ-030 While iRST=1: state=CFG_REQ, index=0, oSPI_REQ=0, oSPI_RW=0, oSPI_ADDR=0, oSPI_WDATA=0, oDIG=0, oDIG_VALID=0, oCFG_DONE=0, oERR=0, oOVR=0, tick counter=0, pending=0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately; oSPI_REQ SHALL go low asynchronously.
REQ-032 The first oSPI_REQ SHALL assert in the first clock after iRST deasserts.

Verification
REQ-033 Reset release, ACK 3 cycles after each REQ -> writes 0x31/0x40, 0x2C/0x09, 0x2D/0x08 in order; oCFG_DONE=1.
REQ-034 SAMPLE_DIV=64, reads returning 0x32->0xFE, 0x33->0x03 -> oDIG=0x3FE (-2), a single oDIG_VALID pulse, one cycle after the RD1 ACK.
REQ-035 With RD1 ACK withheld, TIMEOUT=15 -> oERR=1 after 15 cycles, oDIG unchanged, config sequence restarts at 0x31.
REQ-036 SAMPLE_DIV=64, ACK delay 100 cycles -> oOVR=1 and samples continue without deadlock.
REQ-037 iRST pulsed during RD0_WAIT -> all outputs at reset values; clean reconfiguration after release.
